lfsr_11_bit_checker: RTL and testbench
======================================

LFSR_11_BIT_CHECKER -- requirements
Module: lfsr_11_bit_checker

Interface
- REQ-001 The module SHALL have parameter `MISMATCH_LIMIT`, default 3: the number of consecutive locked-state mismatches that forces loss of lock (legal range 1-7).
- REQ-002 The module SHALL have parameter `COUNT_WIDTH`, default 16: the width of the error counter.
- REQ-003 The module SHALL have port `clock`, input, 1 bit: the single system clock; all logic is on its rising edge.
- REQ-004 The module SHALL have port `reset`, input, 1 bit: reset is synchronous and active-high.
- REQ-005 The module SHALL have port `data_in`, input, 11 bits: the received LFSR sample.
- REQ-006 The module SHALL have port `data_valid`, input, 1 bit: `data_in` is sampled on a clock edge only while this is high.
- REQ-007 The module SHALL have port `locked`, output, 1 bit: high while the state is LOCKED.
- REQ-008 The module SHALL have port `error_pulse`, output, 1 bit: a one-cycle flag marking a mismatch in LOCKED.
- REQ-009 The module SHALL have port `error_count`, output, `COUNT_WIDTH` bits: the saturating total of LOCKED mismatches.
- REQ-010 The module SHALL have port `period_done`, output, 1 bit: a one-cycle flag marking 2047 consecutive matched samples.
- REQ-011 The module SHALL have port `expected`, output, 11 bits: the value predicted for the next valid sample.

Function
- REQ-012 The predictor SHALL use polynomial x^11 + x^9 + 1: next(v) = {v[9:0], v[10] ^ v[8]}, with period 2047 over non-zero states.
- REQ-013 The state machine SHALL have three states: ACQUIRE, VERIFY and LOCKED; it SHALL hold its state on every edge where `data_valid` = 0.
- REQ-014 In ACQUIRE, a valid non-zero sample S SHALL set `expected` to next(S) and move to VERIFY; a valid zero sample SHALL be ignored and the state stays ACQUIRE.
- REQ-015 In VERIFY, a valid sample equal to `expected` SHALL move to LOCKED and advance `expected`.
- REQ-016 In VERIFY, a valid non-zero sample S not equal to `expected` SHALL reseed `expected` to next(S) and stay in VERIFY.
- REQ-017 In VERIFY, a valid zero sample SHALL return the state to ACQUIRE.
- REQ-018 In LOCKED, every valid sample SHALL advance `expected` to next(`expected`), whether or not it matches; the checker never reseeds from the data in LOCKED.
- REQ-019 In LOCKED, a match SHALL clear the consecutive-mismatch counter and increment the match-run counter.
- REQ-020 In LOCKED, a mismatch (including an all-zero sample) SHALL assert `error_pulse`, increment `error_count`, clear the match-run counter and increment the consecutive-mismatch counter.
- REQ-021 When the consecutive-mismatch counter reaches `MISMATCH_LIMIT`, the state SHALL go to ACQUIRE on that same edge, with `locked` low the following cycle; `error_pulse` SHALL still fire for that sample.
- REQ-022 When the match-run counter reaches 2047, `period_done` SHALL pulse and the match-run counter SHALL wrap to 0.
- REQ-023 Mismatches in ACQUIRE or VERIFY SHALL NOT assert `error_pulse` and SHALL NOT change `error_count`.
- REQ-024 `error_count` SHALL saturate at all-ones and never wrap.
- REQ-025 All outputs SHALL be registered, reflecting the sample accepted on the previous edge (latency 1 clock).
- REQ-026 `error_pulse` and `period_done` SHALL be low on any cycle that follows an edge without a valid sample.

Reset
- REQ-027 When `reset` is high on a clock edge, the following SHALL take effect on that edge regardless of `data_valid`: state = ACQUIRE; `locked`, `error_pulse` and `period_done` = 0; `error_count` = 0; both internal counters = 0; `expected` = 11'd0.
- REQ-028 Reset asserted mid-operation SHALL discard the lock immediately; the sample presented on the reset edge SHALL NOT be checked.
- REQ-029 After reset deasserts, acquisition SHALL restart from the first valid non-zero sample.

Verification
- REQ-030 Scenario (lock): feed the generator stream starting 1365 then 682 (11'b10101010101 -> 11'b01010101010) -> `expected` = 682 after the first sample, `locked` = 1 one cycle after the second sample, `error_count` = 0.
- REQ-031 Scenario (single error): once locked, corrupt one sample (flip bit 0) -> exactly one `error_pulse`, `error_count` = 1, `locked` stays 1, and later samples match again.
- REQ-032 Scenario (loss of lock): three consecutive corrupted samples with default `MISMATCH_LIMIT` -> `error_count` = 3 and `locked` = 0 after the third; clean data then relocks after 2 valid samples.
- REQ-033 Scenario (full period): 2049 clean samples with `data_valid` toggled irregularly -> exactly one `period_done` pulse, and no spurious flags on idle cycles.
- REQ-034 Scenario (zero input): all-zero samples in ACQUIRE -> state stays ACQUIRE; an all-zero sample in LOCKED -> counted as an error.
- REQ-035 Scenario (reset mid-stream): assert `reset` while locked with `error_count` = 5 -> `locked` = 0 and `error_count` = 0 the next cycle.
- REQ-036 Scenario (saturation): with `COUNT_WIDTH` = 4, drive 20 mismatches while locked -> `error_count` holds at 15.

Source files
------------

// File: rtl/lfsr_11_bit_checker.sv
// Checker for an 11-bit LFSR stream (x^11 + x^9 + 1): acquires from the data, verifies one
// prediction, then free-runs its own predictor while counting mismatches and full periods.
module lfsr_11_bit_checker #(
   parameter int unsigned MISMATCH_LIMIT = 3,
   parameter int unsigned COUNT_WIDTH    = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [10:0]            data_in,
   input  logic                   data_valid,
   output logic                   locked,
   output logic                   error_pulse,
   output logic [COUNT_WIDTH-1:0] error_count,
   output logic                   period_done,
   output logic [10:0]            expected
);

   typedef enum logic [1:0] {
      StAcquire,
      StVerify,
      StLocked
   } state_e;

   // Run counter holds 0..2046; the match that would make it 2047 closes a period.
   localparam logic [10:0] RunLast  = 11'd2046;
   localparam logic [2:0]  MissLast = 3'(MISMATCH_LIMIT);

   function automatic logic [10:0] lfsr_next(input logic [10:0] v);
      return {v[9:0], v[10] ^ v[8]};
   endfunction

   state_e                 state_q, state_d;
   logic [10:0]            expected_q, expected_d;
   logic [2:0]             miss_q, miss_d;
   logic [10:0]            run_q, run_d;
   logic [COUNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
   logic                   locked_q, locked_d;
   logic                   error_pulse_q, error_pulse_d;
   logic                   period_done_q, period_done_d;

   logic sample_zero;
   logic sample_match;
   logic miss_at_limit;

   assign sample_zero   = (data_in == 11'd0);
   assign sample_match  = (data_in == expected_q);
   assign miss_at_limit = ((miss_q + 3'd1) == MissLast);

   // State register plus all registered datapath and outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= StAcquire;
         expected_q    <= 11'd0;
         miss_q        <= 3'd0;
         run_q         <= 11'd0;
         err_cnt_q     <= '0;
         locked_q      <= 1'b0;
         error_pulse_q <= 1'b0;
         period_done_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         expected_q    <= expected_d;
         miss_q        <= miss_d;
         run_q         <= run_d;
         err_cnt_q     <= err_cnt_d;
         locked_q      <= locked_d;
         error_pulse_q <= error_pulse_d;
         period_done_q <= period_done_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      if (data_valid) begin
         unique case (state_q)
            StAcquire: begin
               if (!sample_zero) begin
                  state_d = StVerify;
               end
            end
            StVerify: begin
               if (sample_zero) begin
                  state_d = StAcquire;
               end else if (sample_match) begin
                  state_d = StLocked;
               end
            end
            StLocked: begin
               if (!sample_match && miss_at_limit) begin
                  state_d = StAcquire;
               end
            end
            default: state_d = StAcquire;
         endcase
      end
   end

   // Datapath and output next values.
   always_comb begin
      expected_d    = expected_q;
      miss_d        = miss_q;
      run_d         = run_q;
      err_cnt_d     = err_cnt_q;
      error_pulse_d = 1'b0;
      period_done_d = 1'b0;
      if (data_valid) begin
         unique case (state_q)
            StAcquire: begin
               if (!sample_zero) begin
                  expected_d = lfsr_next(data_in);
               end
            end
            StVerify: begin
               if (sample_zero) begin
                  expected_d = expected_q;
               end else if (sample_match) begin
                  expected_d = lfsr_next(expected_q);
                  miss_d     = 3'd0;
                  run_d      = 11'd0;
               end else begin
                  expected_d = lfsr_next(data_in);
               end
            end
            StLocked: begin
               // Once locked the predictor free-runs; data never reseeds it.
               expected_d = lfsr_next(expected_q);
               if (sample_match) begin
                  miss_d = 3'd0;
                  if (run_q == RunLast) begin
                     run_d         = 11'd0;
                     period_done_d = 1'b1;
                  end else begin
                     run_d = run_q + 11'd1;
                  end
               end else begin
                  error_pulse_d = 1'b1;
                  run_d         = 11'd0;
                  miss_d        = miss_at_limit ? 3'd0 : miss_q + 3'd1;
                  if (err_cnt_q != {COUNT_WIDTH{1'b1}}) begin
                     err_cnt_d = err_cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               expected_d = expected_q;
            end
         endcase
      end
      locked_d = (state_d == StLocked);
   end

   assign locked      = locked_q;
   assign error_pulse = error_pulse_q;
   assign error_count = err_cnt_q;
   assign period_done = period_done_q;
   assign expected    = expected_q;

endmodule

// File: tb/tb_lfsr_11_bit_checker.sv
// Bench for lfsr_11_bit_checker: fixed vectors, directed multi-cycle scenarios and a randomized
// stream, all checked every cycle against a sample-level reference model.
module tb_lfsr_11_bit_checker;

   localparam int Limit = 3;

   logic        clock = 1'b0;
   logic        reset;
   logic [10:0] data_in;
   logic        data_valid;

   logic        locked, error_pulse, period_done;
   logic [15:0] error_count;
   logic [10:0] expected;
   logic        s_locked, s_error_pulse, s_period_done;
   logic [3:0]  s_error_count;
   logic [10:0] s_expected;

   lfsr_11_bit_checker dut (
      .clock       (clock),
      .reset       (reset),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .locked      (locked),
      .error_pulse (error_pulse),
      .error_count (error_count),
      .period_done (period_done),
      .expected    (expected)
   );

   lfsr_11_bit_checker #(.COUNT_WIDTH(4)) dut_sat (
      .clock       (clock),
      .reset       (reset),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .locked      (s_locked),
      .error_pulse (s_error_pulse),
      .error_count (s_error_count),
      .period_done (s_period_done),
      .expected    (s_expected)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model: mode 0 = acquire, 1 = verify, 2 = locked.
   int m_mode, m_pred, m_miss, m_run, m_errs;
   bit m_lk, m_ep, m_pd;

   int pd_cnt, idle_flags;

   function automatic int nx(int v);
      return ((v << 1) & 2047) | (((v >> 10) ^ (v >> 8)) & 1);
   endfunction

   function automatic int sat(int v, int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   task automatic check(string name, longint act, longint req);
      n_checks++;
      if (act != req) begin
         n_fails++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic model_step(bit rst, bit vld, int d);
      if (rst) begin
         m_mode = 0; m_pred = 0; m_miss = 0; m_run = 0; m_errs = 0;
         m_ep = 0; m_pd = 0;
      end else begin
         m_ep = 0;
         m_pd = 0;
         if (vld) begin
            if (m_mode == 0) begin
               if (d != 0) begin
                  m_pred = nx(d);
                  m_mode = 1;
               end
            end else if (m_mode == 1) begin
               if (d == 0) m_mode = 0;
               else if (d == m_pred) begin
                  m_pred = nx(m_pred);
                  m_mode = 2; m_miss = 0; m_run = 0;
               end else m_pred = nx(d);
            end else begin
               if (d == m_pred) begin
                  m_miss = 0;
                  m_run++;
                  if (m_run == 2047) begin
                     m_pd = 1;
                     m_run = 0;
                  end
               end else begin
                  m_ep = 1;
                  m_errs++;
                  m_run = 0;
                  m_miss++;
                  if (m_miss == Limit) begin
                     m_mode = 0;
                     m_miss = 0;
                  end
               end
               m_pred = nx(m_pred);
            end
         end
      end
      m_lk = (m_mode == 2);
   endtask

   task automatic step(bit rst, bit vld, int d);
      int dv;
      dv = d;
      reset      = rst;
      data_valid = vld;
      data_in    = dv[10:0];
      @(posedge clock);
      #1;
      model_step(rst, vld, d);
      if (period_done) pd_cnt++;
      if (!vld && (period_done || error_pulse)) idle_flags++;
      check("locked", locked, m_lk);
      check("error_pulse", error_pulse, m_ep);
      check("period_done", period_done, m_pd);
      check("expected", expected, m_pred);
      check("error_count", error_count, sat(m_errs, 65535));
      check("sat_error_count", s_error_count, sat(m_errs, 15));
   endtask

   typedef struct {
      bit rst;
      bit vld;
      int data;
      bit lk;
      bit ep;
      int ecount;
      int expv;
   } vec_t;

   vec_t tab[9];
   int   g;

   task automatic lock_on(int seed);
      g = seed;
      step(0, 1, g); g = nx(g);
      step(0, 1, g); g = nx(g);
   endtask

   initial begin
      reset = 1'b1; data_valid = 1'b0; data_in = 11'd0;

      // rst, vld, data, locked, error_pulse, error_count, expected
      tab[0] = '{1, 0, 0,    0, 0, 0, 0};
      tab[1] = '{0, 1, 1365, 0, 0, 0, 682};
      tab[2] = '{0, 1, 682,  1, 0, 0, 1364};
      tab[3] = '{0, 0, 99,   1, 0, 0, 1364};
      tab[4] = '{0, 1, 1365, 1, 1, 1, 680};
      tab[5] = '{0, 1, 680,  1, 0, 1, 1360};
      tab[6] = '{0, 1, 0,    1, 1, 2, 672};
      tab[7] = '{1, 1, 672,  0, 0, 0, 0};
      tab[8] = '{0, 1, 0,    0, 0, 0, 0};
      for (int i = 0; i < 9; i++) begin
         step(tab[i].rst, tab[i].vld, tab[i].data);
         check($sformatf("vec%0d_locked", i), locked, tab[i].lk);
         check($sformatf("vec%0d_error_pulse", i), error_pulse, tab[i].ep);
         check($sformatf("vec%0d_error_count", i), error_count, tab[i].ecount);
         check($sformatf("vec%0d_expected", i), expected, tab[i].expv);
      end

      // Zeros in acquire are ignored.
      for (int i = 0; i < 3; i++) step(0, 1, 0);
      check("zero_acq_locked", locked, 0);

      // Loss of lock after three consecutive corrupted samples, then relock.
      step(1, 0, 0);
      lock_on(1365);
      check("lol_locked_start", locked, 1);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, g ^ 1); g = nx(g);
         if (i == 1) check("lol_locked_after2", locked, 1);
      end
      check("lol_error_count", error_count, 3);
      check("lol_locked_after3", locked, 0);
      step(0, 1, g); g = nx(g);
      check("relock_after1", locked, 0);
      step(0, 1, g); g = nx(g);
      check("relock_after2", locked, 1);

      // Reset mid-stream with five errors recorded.
      step(1, 0, 0);
      lock_on(77);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, g ^ 4); g = nx(g);
         if (i % 2 == 1) begin
            step(0, 1, g); g = nx(g);
         end
      end
      check("mid_error_count", error_count, 5);
      check("mid_locked", locked, 1);
      step(1, 1, g); g = nx(g);
      check("mid_reset_locked", locked, 0);
      check("mid_reset_error_count", error_count, 0);

      // Saturation: 20 mismatches without ever reaching the loss-of-lock limit.
      lock_on(300);
      for (int i = 0; i < 10; i++) begin
         step(0, 1, g ^ 2); g = nx(g);
         step(0, 1, g ^ 2); g = nx(g);
         step(0, 1, g); g = nx(g);
      end
      check("sat_count_w4", s_error_count, 15);
      check("sat_count_w16", error_count, 20);
      check("sat_locked", locked, 1);

      // Full period: 2049 clean samples with irregular valid.
      step(1, 0, 0);
      pd_cnt = 0; idle_flags = 0;
      g = 1;
      for (int i = 0; i < 2049; i++) begin
         while ($urandom_range(0, 3) == 0) step(0, 0, $urandom_range(0, 2047));
         step(0, 1, g); g = nx(g);
      end
      step(0, 0, 0);
      check("period_pulses", pd_cnt, 1);
      check("idle_flags", idle_flags, 0);

      // Randomized stream.
      for (int i = 0; i < 4000; i++) begin
         int r, v;
         r = $urandom_range(0, 99);
         if (r < 2) step(1, $urandom_range(0, 1), g);
         else if (r < 25) step(0, 0, $urandom_range(0, 2047));
         else if (r < 32) begin
            step(0, 1, g ^ $urandom_range(1, 2047)); g = nx(g);
         end else if (r < 34) begin
            step(0, 1, 0); g = nx(g);
         end else if (r < 37) begin
            v = $urandom_range(1, 2047);
            step(0, 1, v); g = nx(v);
         end else begin
            step(0, 1, g); g = nx(g);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
